// File: rtl/axi_ad9361_tx_upack_if.sv
// DMA-side word handshake of the tx unpacker: one 64-bit word of four 16-bit samples.
interface axi_ad9361_tx_upack_if;
  logic        dma_valid;
  logic [63:0] dma_data;
  logic        dma_ready;

  modport master (output dma_valid, output dma_data, input dma_ready);
  modport slave  (input dma_valid, input dma_data, output dma_ready);
endinterface

// File: rtl/axi_ad9361_tx_upack.sv
// Unpacks 64-bit DMA words into per-channel 16-bit samples, spread over the
// enabled channels (1, 2 or 4) at one slot per dac_valid strobe.
module axi_ad9361_tx_upack #(
  parameter bit UNDERFLOW_HOLD = 1'b0
) (
  input  logic                         dac_clk,
  input  logic                         dac_rstn,
  axi_ad9361_tx_upack_if.slave         dma,
  input  logic                         dac_valid,
  input  logic                         dac_enable_i0,
  input  logic                         dac_enable_q0,
  input  logic                         dac_enable_i1,
  input  logic                         dac_enable_q1,
  output logic [15:0]                  dac_data_i0,
  output logic [15:0]                  dac_data_q0,
  output logic [15:0]                  dac_data_i1,
  output logic [15:0]                  dac_data_q1,
  output logic                         dac_dunf,
  output logic                         dac_cfg_err
);

  logic [63:0]      word;
  logic             word_valid;
  logic [1:0]       slot;
  logic [3:0]       en_in;
  logic [3:0]       en_q;
  logic [2:0]       n;
  logic             config_ok;
  logic             flush;
  logic             last_slot;
  logic             xfer;
  logic [3:0][15:0] slot_data;
  logic [3:0][15:0] data_q;

  assign en_in = {dac_enable_q1, dac_enable_i1, dac_enable_q0, dac_enable_i0};

  always_comb begin
    n = 3'(en_q[0]) + 3'(en_q[1]) + 3'(en_q[2]) + 3'(en_q[3]);
    config_ok = (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
    case (n)
      3'd1:    last_slot = (slot == 2'd3);
      3'd2:    last_slot = (slot == 2'd1);
      default: last_slot = 1'b1;
    endcase
  end

  // A pending enable change flushes at this edge, so it also blocks the transfer.
  assign flush         = (en_in != en_q);
  assign dma.dma_ready = (!word_valid | (dac_valid & last_slot)) & config_ok & !flush;
  assign xfer          = dma.dma_valid & dma.dma_ready;

  // Slot k starts at sample k*n; enabled channels take consecutive samples.
  always_comb begin
    logic [1:0] idx;
    case (n)
      3'd1:    idx = slot;
      3'd2:    idx = {slot[0], 1'b0};
      default: idx = 2'd0;
    endcase
    slot_data = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (en_q[c]) begin
        slot_data[c] = word[{idx, 4'b0000} +: 16];
        idx = idx + 2'd1;
      end
    end
  end

  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      word        <= '0;
      word_valid  <= 1'b0;
      slot        <= '0;
      en_q        <= '0;
      data_q      <= '0;
      dac_dunf    <= 1'b0;
      dac_cfg_err <= 1'b0;
    end else begin
      en_q        <= en_in;
      dac_cfg_err <= (n == 3'd3);
      dac_dunf    <= 1'b0;
      if (flush) begin
        word_valid <= 1'b0;
        slot       <= '0;
        data_q     <= '0;
      end else if (!config_ok) begin
        data_q <= '0;
      end else begin
        if (dac_valid) begin
          if (word_valid) begin
            data_q <= slot_data;
            if (last_slot) begin
              word_valid <= 1'b0;
            end else begin
              slot <= slot + 2'd1;
            end
          end else begin
            dac_dunf <= 1'b1;
            if (!UNDERFLOW_HOLD) begin
              data_q <= '0;
            end
          end
        end
        // A refill overrides the clear above; on underflow the word is only loaded.
        if (xfer) begin
          word       <= dma.dma_data;
          word_valid <= 1'b1;
          slot       <= '0;
        end
      end
    end
  end

  assign dac_data_i0 = data_q[0];
  assign dac_data_q0 = data_q[1];
  assign dac_data_i1 = data_q[2];
  assign dac_data_q1 = data_q[3];

endmodule

// File: tb/tb_axi_ad9361_tx_upack.sv
// Self-checking bench: two instances (zero-fill and hold on underflow) against a sample-queue model.
module tb_axi_ad9361_tx_upack;

  logic dac_clk = 1'b0;
  always #5 dac_clk = ~dac_clk;

  logic        dac_rstn;
  logic        dac_valid;
  logic [3:0]  en;
  logic [15:0] d0 [4];
  logic [15:0] d1 [4];
  logic        dunf0, dunf1, cerr0, cerr1;

  axi_ad9361_tx_upack_if dma0 ();
  axi_ad9361_tx_upack_if dma1 ();
  assign dma1.dma_valid = dma0.dma_valid;
  assign dma1.dma_data  = dma0.dma_data;

  axi_ad9361_tx_upack #(.UNDERFLOW_HOLD(1'b0)) dut0 (
    .dac_clk(dac_clk), .dac_rstn(dac_rstn), .dma(dma0), .dac_valid(dac_valid),
    .dac_enable_i0(en[0]), .dac_enable_q0(en[1]), .dac_enable_i1(en[2]), .dac_enable_q1(en[3]),
    .dac_data_i0(d0[0]), .dac_data_q0(d0[1]), .dac_data_i1(d0[2]), .dac_data_q1(d0[3]),
    .dac_dunf(dunf0), .dac_cfg_err(cerr0));

  axi_ad9361_tx_upack #(.UNDERFLOW_HOLD(1'b1)) dut1 (
    .dac_clk(dac_clk), .dac_rstn(dac_rstn), .dma(dma1), .dac_valid(dac_valid),
    .dac_enable_i0(en[0]), .dac_enable_q0(en[1]), .dac_enable_i1(en[2]), .dac_enable_q1(en[3]),
    .dac_data_i0(d1[0]), .dac_data_q0(d1[1]), .dac_data_i1(d1[2]), .dac_data_q1(d1[3]),
    .dac_dunf(dunf1), .dac_cfg_err(cerr1));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: queue of not-yet-played samples, expected outputs per instance.
  logic [15:0] q [$];
  logic [15:0] e0 [4];
  logic [15:0] e1 [4];
  logic        edunf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_zero_out"}, d0[c], e0[c]);
      chk({tag, "_hold_out"}, d1[c], e1[c]);
    end
    chk({tag, "_dunf0"}, dunf0, edunf);
    chk({tag, "_dunf1"}, dunf1, edunf);
  endtask

  task automatic clear_model();
    q.delete();
    edunf = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e0[c] = '0;
      e1[c] = '0;
    end
  endtask

  // One clock: drive, check ready, advance model, check registered outputs.
  task automatic step(input logic dv, input logic dmv, input logic [63:0] data);
    int   nch;
    logic rdy;
    nch = $countones(en);
    dac_valid      = dv;
    dma0.dma_valid = dmv;
    dma0.dma_data  = data;
    #1;
    rdy = (q.size() == 0) || (dv && q.size() == nch);
    chk("ready0", dma0.dma_ready, rdy);
    chk("ready1", dma1.dma_ready, rdy);
    edunf = 1'b0;
    if (dv) begin
      if (q.size() == 0) begin
        edunf = 1'b1;
        for (int c = 0; c < 4; c++) e0[c] = '0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (en[c]) begin
            e0[c] = q.pop_front();
            e1[c] = e0[c];
          end
        end
      end
    end
    if (dmv && rdy) begin
      for (int s = 0; s < 4; s++) q.push_back(data[16*s +: 16]);
    end
    @(posedge dac_clk);
    @(negedge dac_clk);
    dma0.dma_valid = 1'b0;
    dac_valid      = 1'b0;
    chk_outputs("step");
  endtask

  task automatic flush_wait();
    dac_valid      = 1'b0;
    dma0.dma_valid = 1'b1;
    dma0.dma_data  = {$urandom, $urandom};
    #1;
    chk("flush_ready", dma0.dma_ready, 1'b0);
    @(posedge dac_clk);
    @(negedge dac_clk);
    dma0.dma_valid = 1'b0;
    repeat (2) @(negedge dac_clk);
    clear_model();
    chk("cfg_err0", cerr0, ($countones(en) == 3));
    chk("cfg_err1", cerr1, ($countones(en) == 3));
    chk_outputs("flush");
  endtask

  task automatic set_en(input logic [3:0] v);
    en = v;
    flush_wait();
  endtask

  initial begin
    logic [3:0] v;
    dac_rstn       = 1'b0;
    en             = 4'b0000;
    dac_valid      = 1'b0;
    dma0.dma_valid = 1'b0;
    dma0.dma_data  = '0;
    clear_model();
    repeat (3) @(negedge dac_clk);
    chk_outputs("reset");
    chk("reset_ready", dma0.dma_ready, 1'b0);
    chk("reset_cfg_err", cerr0, 1'b0);
    dac_rstn = 1'b1;

    // Four channels, one word per strobe.
    set_en(4'b1111);
    step(1'b0, 1'b1, 64'h4444_3333_2222_1111);
    step(1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);

    // i0/q0: two slots per word.
    set_en(4'b0011);
    step(1'b0, 1'b1, 64'hDDDD_CCCC_BBBB_AAAA);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);

    // q1 only: four slots, no second transfer while slots remain.
    set_en(4'b1000);
    step(1'b0, 1'b1, 64'h0004_0003_0002_0001);
    repeat (3) step(1'b1, 1'b1, 64'hFFFF_EEEE_9999_8888);
    step(1'b1, 1'b0, 64'h0);

    // Underflow: zero-fill vs hold, single-cycle pulse.
    step(1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b0, 64'h0);

    // Enables change mid-word, then restart at slot 0.
    set_en(4'b1111);
    step(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    set_en(4'b0011);
    step(1'b0, 1'b1, 64'h0D0D_0C0C_0B0B_0A0A);
    step(1'b1, 1'b0, 64'h0);

    // Three channels: config error, no ready, strobes ignored.
    set_en(4'b0111);
    dac_valid      = 1'b1;
    dma0.dma_valid = 1'b1;
    #1;
    chk("cfg3_ready", dma0.dma_ready, 1'b0);
    @(posedge dac_clk);
    @(negedge dac_clk);
    dac_valid      = 1'b0;
    dma0.dma_valid = 1'b0;
    chk_outputs("cfg3");
    chk("cfg3_err", cerr0, 1'b1);
    set_en(4'b0001);

    // Reset during n=1 slot 2.
    step(1'b0, 1'b1, 64'h5555_6666_7777_8888);
    step(1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b0, 64'h0);
    dac_rstn = 1'b0;
    #1;
    clear_model();
    chk_outputs("async_reset");
    @(negedge dac_clk);
    dac_rstn = 1'b1;
    flush_wait();
    step(1'b1, 1'b0, 64'h0);

    // Randomised traffic across supported enable patterns.
    for (int r = 0; r < 6; r++) begin
      do v = 4'($urandom_range(1, 15));
      while (!($countones(v) inside {1, 2, 4}) || v == en);
      set_en(v);
      for (int i = 0; i < 60; i++) begin
        step(($urandom % 4) != 0, ($urandom % 3) != 0, {$urandom, $urandom});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
